// File: rtl/bc_display_pkg.sv
// Shared definitions for the BullsAndCows 7-segment display path.
// Holds the digit-code field layout, character codes, segment constants and
// the scan FSM state type used by the display driver and its font decoder.
package bc_display_pkg;

    localparam int unsigned NUM_DIGITS = 8;
    localparam int unsigned CODE_W     = 7;
    localparam int unsigned CHAR_W     = 5;
    localparam int unsigned SEG_W      = 7;
    localparam int unsigned AN_W       = NUM_DIGITS;
    localparam int unsigned IDX_W      = 3;

    // Digit code layout: {enable, char[4:0], raw dp level}
    localparam int unsigned EN_BIT   = 6;
    localparam int unsigned CHAR_MSB = 5;
    localparam int unsigned CHAR_LSB = 1;
    localparam int unsigned DP_BIT   = 0;

    typedef logic [CODE_W-1:0] disp_code_t;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_t;

    // Character codes
    localparam logic [CHAR_W-1:0] CH_0     = 5'h00;
    localparam logic [CHAR_W-1:0] CH_1     = 5'h01;
    localparam logic [CHAR_W-1:0] CH_2     = 5'h02;
    localparam logic [CHAR_W-1:0] CH_3     = 5'h03;
    localparam logic [CHAR_W-1:0] CH_4     = 5'h04;
    localparam logic [CHAR_W-1:0] CH_J     = 5'h05;
    localparam logic [CHAR_W-1:0] CH_S     = 5'h06;
    localparam logic [CHAR_W-1:0] CH_E     = 5'h07;
    localparam logic [CHAR_W-1:0] CH_T     = 5'h08;
    localparam logic [CHAR_W-1:0] CH_U     = 5'h09;
    localparam logic [CHAR_W-1:0] CH_P     = 5'h0A;
    localparam logic [CHAR_W-1:0] CH_B     = 5'h0B;
    localparam logic [CHAR_W-1:0] CH_C     = 5'h0C;
    localparam logic [CHAR_W-1:0] CH_L     = 5'h0D;
    localparam logic [CHAR_W-1:0] CH_Y     = 5'h0E;
    localparam logic [CHAR_W-1:0] CH_G     = 5'h0F;
    localparam logic [CHAR_W-1:0] CH_BLANK = 5'h10;
    localparam logic [CHAR_W-1:0] CH_DASH  = 5'h11;

    // Active-low cathode patterns {g,f,e,d,c,b,a}
    localparam logic [SEG_W-1:0] SEG_OFF    = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_ALL_ON = 7'h00;

endpackage

// File: rtl/bc_seg_font.sv
// Character to 7-segment decode (combinational, active-low cathodes).
// Ports:
//   char_code  in  5  character code from the digit code char field
//   seg_c      out 7  {g,f,e,d,c,b,a}, 0 = segment lit; unknown codes blank
module bc_seg_font
    import bc_display_pkg::*;
(
    input  logic [CHAR_W-1:0] char_code,
    output logic [SEG_W-1:0]  seg_c
);

    always_comb begin
        seg_c = SEG_OFF;
        case (char_code)
            CH_0:     seg_c = 7'b1000000;
            CH_1:     seg_c = 7'b1111001;
            CH_2:     seg_c = 7'b0100100;
            CH_3:     seg_c = 7'b0110000;
            CH_4:     seg_c = 7'b0011001;
            CH_J:     seg_c = 7'b1100001;
            CH_S:     seg_c = 7'b0010010;
            CH_E:     seg_c = 7'b0000110;
            CH_T:     seg_c = 7'b0000111;
            CH_U:     seg_c = 7'b1000001;
            CH_P:     seg_c = 7'b0001100;
            CH_B:     seg_c = 7'b0000011;
            CH_C:     seg_c = 7'b1000110;
            CH_L:     seg_c = 7'b1000111;
            CH_Y:     seg_c = 7'b0010001;
            CH_G:     seg_c = 7'b1000010;
            CH_DASH:  seg_c = 7'b0111111;
            default:  seg_c = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/bc_seg_scan_driver.sv
// Multiplexed 8-digit 7-segment scan driver for the Nexys A7 display.
// Each digit slot starts with BLANK_TICKS cycles of all anodes off (ghost
// blanking) followed by DIGIT_TICKS-BLANK_TICKS cycles showing the digit.
// All eight codes are snapshotted once per frame to avoid tearing.
// Ports:
//   clock      in   1  system clock
//   reset_n    in   1  asynchronous active-low reset
//   d1..d8     in   7  digit codes {en, char[4:0], dp}; d1 = AN[0] (rightmost)
//   lamp_test  in   1  light every segment and DP of every digit while showing
//   an         out  8  anode enables, active-low (registered)
//   seg        out  7  cathodes {CG..CA}, active-low (registered)
//   dp         out  1  decimal point cathode, active-low (registered)
module bc_seg_scan_driver
    import bc_display_pkg::*;
#(
    parameter int unsigned DIGIT_TICKS = 100_000,
    parameter int unsigned BLANK_TICKS = 100
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [CODE_W-1:0] d1,
    input  logic [CODE_W-1:0] d2,
    input  logic [CODE_W-1:0] d3,
    input  logic [CODE_W-1:0] d4,
    input  logic [CODE_W-1:0] d5,
    input  logic [CODE_W-1:0] d6,
    input  logic [CODE_W-1:0] d7,
    input  logic [CODE_W-1:0] d8,
    input  logic              lamp_test,
    output logic [AN_W-1:0]   an,
    output logic [SEG_W-1:0]  seg,
    output logic              dp
);

    localparam int unsigned TICK_W = $clog2(DIGIT_TICKS);
    localparam logic [TICK_W-1:0] BLANK_LAST = TICK_W'(BLANK_TICKS - 1);
    localparam logic [TICK_W-1:0] SHOW_LAST  = TICK_W'(DIGIT_TICKS - BLANK_TICKS - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    scan_state_t                  state_q, state_d;
    logic [TICK_W-1:0]            tick_q, tick_d;
    logic [IDX_W-1:0]             idx_q, idx_d;
    logic                         first_q, first_d;
    disp_code_t [NUM_DIGITS-1:0]  shadow_q, shadow_d;
    logic [AN_W-1:0]              an_q, an_d;
    logic [SEG_W-1:0]             seg_q, seg_d;
    logic                         dp_q, dp_d;

    disp_code_t [NUM_DIGITS-1:0]  d_bus_c;
    disp_code_t                   sel_code_c;
    logic [SEG_W-1:0]             font_seg_c;
    logic                         latch_c;

    assign d_bus_c = {d8, d7, d6, d5, d4, d3, d2, d1};

    // Slot sequencing and frame snapshot
    always_comb begin
        state_d  = state_q;
        tick_d   = tick_q + TICK_W'(1);
        idx_d    = idx_q;
        first_d  = 1'b0;
        shadow_d = shadow_q;
        latch_c  = 1'b0;
        case (state_q)
            BLANK: begin
                if (tick_q == BLANK_LAST) begin
                    state_d = SHOW;
                    tick_d  = '0;
                end
            end
            SHOW: begin
                if (tick_q == SHOW_LAST) begin
                    state_d = BLANK;
                    tick_d  = '0;
                    idx_d   = idx_q + IDX_W'(1);
                    // Entering BLANK of slot 0 starts a new frame
                    if (idx_q == IDX_LAST) begin
                        latch_c = 1'b1;
                    end
                end
            end
            default: begin
                state_d = BLANK;
                tick_d  = '0;
            end
        endcase
        // Reset leaves us already inside BLANK of slot 0; latch on the first edge
        if (first_q) begin
            latch_c = 1'b1;
        end
        if (latch_c) begin
            shadow_d = d_bus_c;
        end
    end

    // Look up the next-cycle digit so outputs change on the state-entry edge
    assign sel_code_c = shadow_d[idx_d];

    bc_seg_font u_font (
        .char_code (sel_code_c[CHAR_MSB:CHAR_LSB]),
        .seg_c     (font_seg_c)
    );

    // Registered pin values for the upcoming cycle
    always_comb begin
        an_d  = '1;
        seg_d = SEG_OFF;
        dp_d  = 1'b1;
        if (state_d == SHOW) begin
            if (lamp_test) begin
                an_d  = ~(AN_W'(1) << idx_d);
                seg_d = SEG_ALL_ON;
                dp_d  = 1'b0;
            end else begin
                an_d  = sel_code_c[EN_BIT] ? ~(AN_W'(1) << idx_d) : '1;
                seg_d = font_seg_c;
                dp_d  = sel_code_c[DP_BIT];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= BLANK;
            tick_q   <= '0;
            idx_q    <= '0;
            first_q  <= 1'b1;
            shadow_q <= '0;
            an_q     <= '1;
            seg_q    <= SEG_OFF;
            dp_q     <= 1'b1;
        end else begin
            state_q  <= state_d;
            tick_q   <= tick_d;
            idx_q    <= idx_d;
            first_q  <= first_d;
            shadow_q <= shadow_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
            dp_q     <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule
